// File: rtl/rx_concat_packer_pkg.sv
// ---------------------------------------------------------------------------
// rx_concat_packer_pkg
// Shared constants and helpers for the receive-side 8-to-64 packer.
//   N1 / N2      : wide-side and MAC-side data widths
//   KEEP_W       : number of byte lanes in a wide beat
//   IDX_W        : width of the byte-lane index
//   ABORT_*      : fields of the beat that closes an aborted frame as bad
//   keep_from_idx: contiguous-low byte-enable mask covering lanes 0..idx
// ---------------------------------------------------------------------------
package rx_concat_packer_pkg;

    localparam int N1     = 64;
    localparam int N2     = 8;
    localparam int KEEP_W = N1 / N2;
    localparam int IDX_W  = $clog2(KEEP_W);

    localparam logic [N1-1:0]     ABORT_DATA = {N1{1'b0}};
    localparam logic [KEEP_W-1:0] ABORT_KEEP = 8'h01;
    localparam logic              ABORT_LAST = 1'b1;
    localparam logic              ABORT_USER = 1'b1;

    // Lanes 0..idx enabled, all higher lanes disabled.
    function automatic logic [KEEP_W-1:0] keep_from_idx(input logic [IDX_W-1:0] idx);
        logic [KEEP_W-1:0] keep;
        for (int k = 0; k < KEEP_W; k++) begin
            keep[k] = (k <= int'(idx));
        end
        return keep;
    endfunction

endpackage

// File: rtl/rx_concat_out_reg.sv
// ---------------------------------------------------------------------------
// rx_concat_out_reg
// One-entry AXI-stream holding register for the wide receive side. Both
// packed data words and abort beats are loaded through here.
//   clk, reset          : clock, asynchronous active-high reset
//   load, load_*        : load request and the beat to load
//   tready              : downstream ready
//   tdata..tuser        : registered AXI-stream outputs
//   full                : register currently holds a beat
//   can_load            : a load this edge is accepted (empty or draining)
// ---------------------------------------------------------------------------
module rx_concat_out_reg
    import rx_concat_packer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [N1-1:0]     load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              load_last,
    input  logic              load_user,
    input  logic              tready,
    output logic [N1-1:0]     tdata,
    output logic [KEEP_W-1:0] tkeep,
    output logic              tvalid,
    output logic              tlast,
    output logic              tuser,
    output logic              full,
    output logic              can_load
);

    assign full     = tvalid;
    assign can_load = !tvalid || tready;

    // Holding register: load wins over drain so back-to-back beats are possible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tdata  <= {N1{1'b0}};
            tkeep  <= {KEEP_W{1'b0}};
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            tuser  <= 1'b0;
        end else if (load) begin
            tdata  <= load_data;
            tkeep  <= load_keep;
            tvalid <= 1'b1;
            tlast  <= load_last;
            tuser  <= load_user;
        end else if (tvalid && tready) begin
            tdata  <= {N1{1'b0}};
            tkeep  <= {KEEP_W{1'b0}};
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            tuser  <= 1'b0;
        end else begin
            tdata  <= tdata;
            tkeep  <= tkeep;
            tvalid <= tvalid;
            tlast  <= tlast;
            tuser  <= tuser;
        end
    end

endmodule

// File: rtl/rx_concat_packer.sv
// ---------------------------------------------------------------------------
// rx_concat_packer
// Packs the MAC's unstallable 8-bit receive stream into 64-bit beats with a
// contiguous-low tkeep. If a word completes while the output is stalled, the
// rest of the frame is dropped and a one-byte bad beat closes it downstream.
//   clk, reset            : clock, asynchronous active-high reset
//   rx_axis_mac_*         : 8-bit MAC stream (tdata, tvalid, tlast, tuser)
//   rx_axis_*             : 64-bit packed stream (tdata, tkeep, tvalid,
//                           tlast, tuser, tready)
//   rx_overflow           : one-cycle pulse per frame lost to overflow
// ---------------------------------------------------------------------------
module rx_concat_packer
    import rx_concat_packer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [N2-1:0]     rx_axis_mac_tdata,
    input  logic              rx_axis_mac_tvalid,
    input  logic              rx_axis_mac_tlast,
    input  logic              rx_axis_mac_tuser,
    output logic [N1-1:0]     rx_axis_tdata,
    output logic [KEEP_W-1:0] rx_axis_tkeep,
    output logic              rx_axis_tvalid,
    output logic              rx_axis_tlast,
    output logic              rx_axis_tuser,
    input  logic              rx_axis_tready,
    output logic              rx_overflow
);

    logic [IDX_W-1:0]  idx_r;
    logic [N1-1:0]     asm_r;
    logic              abort_pending_r;
    logic              discard_to_eof_r;
    logic              overflow_r;

    logic [IDX_W-1:0]  idx_nxt_s;
    logic [N1-1:0]     asm_nxt_s;
    logic              abort_nxt_s;
    logic              discard_nxt_s;
    logic              overflow_s;

    logic              load_s;
    logic [N1-1:0]     load_data_s;
    logic [KEEP_W-1:0] load_keep_s;
    logic              load_last_s;
    logic              load_user_s;

    logic              full_s;
    logic              can_load_s;
    logic              drop_mode_s;
    logic              complete_s;
    logic [N1-1:0]     byte_lane_s;
    logic [N1-1:0]     merged_s;

    assign drop_mode_s = abort_pending_r || discard_to_eof_r;
    assign complete_s  = (idx_r == IDX_W'(KEEP_W - 1)) || rx_axis_mac_tlast;
    assign byte_lane_s = {{(N1-N2){1'b0}}, rx_axis_mac_tdata} << {idx_r, 3'b000};
    // Lanes above idx are always zero in asm_r, so OR-merging is safe.
    assign merged_s    = asm_r | byte_lane_s;

    // Packing, overflow detection and drop/abort control.
    always_comb begin
        idx_nxt_s     = idx_r;
        asm_nxt_s     = asm_r;
        abort_nxt_s   = abort_pending_r;
        discard_nxt_s = discard_to_eof_r;
        overflow_s    = 1'b0;
        load_s        = 1'b0;
        load_data_s   = {N1{1'b0}};
        load_keep_s   = {KEEP_W{1'b0}};
        load_last_s   = 1'b0;
        load_user_s   = 1'b0;

        if (drop_mode_s) begin
            // Close the lost frame with a bad one-byte beat once there is room.
            if (abort_pending_r && can_load_s) begin
                load_s      = 1'b1;
                load_data_s = ABORT_DATA;
                load_keep_s = ABORT_KEEP;
                load_last_s = ABORT_LAST;
                load_user_s = ABORT_USER;
                abort_nxt_s = 1'b0;
            end else begin
                abort_nxt_s = abort_pending_r;
            end

            if (rx_axis_mac_tvalid) begin
                if (rx_axis_mac_tlast) begin
                    discard_nxt_s = 1'b0;
                end else if (!discard_to_eof_r && abort_pending_r) begin
                    // A new frame starts before the abort beat went out: drop it whole.
                    discard_nxt_s = 1'b1;
                end else begin
                    discard_nxt_s = discard_to_eof_r;
                end
            end else begin
                discard_nxt_s = discard_to_eof_r;
            end
        end else if (rx_axis_mac_tvalid) begin
            if (complete_s) begin
                idx_nxt_s = {IDX_W{1'b0}};
                asm_nxt_s = {N1{1'b0}};
                if (full_s && !rx_axis_tready) begin
                    overflow_s    = 1'b1;
                    abort_nxt_s   = 1'b1;
                    discard_nxt_s = !rx_axis_mac_tlast;
                end else begin
                    load_s      = 1'b1;
                    load_data_s = merged_s;
                    load_keep_s = keep_from_idx(idx_r);
                    load_last_s = rx_axis_mac_tlast;
                    load_user_s = rx_axis_mac_tlast && rx_axis_mac_tuser;
                end
            end else begin
                idx_nxt_s = idx_r + IDX_W'(1);
                asm_nxt_s = merged_s;
            end
        end else begin
            idx_nxt_s = idx_r;
            asm_nxt_s = asm_r;
        end
    end

    // Packing state and the registered overflow pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r            <= {IDX_W{1'b0}};
            asm_r            <= {N1{1'b0}};
            abort_pending_r  <= 1'b0;
            discard_to_eof_r <= 1'b0;
            overflow_r       <= 1'b0;
        end else begin
            idx_r            <= idx_nxt_s;
            asm_r            <= asm_nxt_s;
            abort_pending_r  <= abort_nxt_s;
            discard_to_eof_r <= discard_nxt_s;
            overflow_r       <= overflow_s;
        end
    end

    assign rx_overflow = overflow_r;

    rx_concat_out_reg u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .load_data (load_data_s),
        .load_keep (load_keep_s),
        .load_last (load_last_s),
        .load_user (load_user_s),
        .tready    (rx_axis_tready),
        .tdata     (rx_axis_tdata),
        .tkeep     (rx_axis_tkeep),
        .tvalid    (rx_axis_tvalid),
        .tlast     (rx_axis_tlast),
        .tuser     (rx_axis_tuser),
        .full      (full_s),
        .can_load  (can_load_s)
    );

endmodule

// File: tb/tb_rx_concat_packer.sv
// ---------------------------------------------------------------------------
// tb_rx_concat_packer
// Directed stimulus with a scoreboard: expected beats are queued when frames
// are sent; a negedge monitor compares every handshaken output beat.
// ---------------------------------------------------------------------------
module tb_rx_concat_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  mac_tdata = 8'h00;
    logic        mac_tvalid = 1'b0;
    logic        mac_tlast = 1'b0;
    logic        mac_tuser = 1'b0;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tuser;
    logic        tready = 1'b1;
    logic        overflow;

    logic [73:0] exp_q[$];
    int          hs_cyc_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          ovf_cnt = 0;

    always #5 clk = ~clk;

    rx_concat_packer dut (
        .clk                (clk),
        .reset              (reset),
        .rx_axis_mac_tdata  (mac_tdata),
        .rx_axis_mac_tvalid (mac_tvalid),
        .rx_axis_mac_tlast  (mac_tlast),
        .rx_axis_mac_tuser  (mac_tuser),
        .rx_axis_tdata      (tdata),
        .rx_axis_tkeep      (tkeep),
        .rx_axis_tvalid     (tvalid),
        .rx_axis_tlast      (tlast),
        .rx_axis_tuser      (tuser),
        .rx_axis_tready     (tready),
        .rx_overflow        (overflow)
    );

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Monitor: compare each handshaken beat with the scoreboard head.
    initial begin
        logic [73:0] act;
        logic [73:0] e;
        forever begin
            @(negedge clk);
            if (overflow) ovf_cnt = ovf_cnt + 1;
            if (!reset && tvalid && tready) begin
                act = {tdata, tkeep, tlast, tuser};
                n_checks = n_checks + 1;
                if (exp_q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL beat_unexpected: got data=%h keep=%h last=%b user=%b, none expected",
                             tdata, tkeep, tlast, tuser);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_fail = n_fail + 1;
                        $display("FAIL beat: got data=%h keep=%h last=%b user=%b, expected data=%h keep=%h last=%b user=%b",
                                 tdata, tkeep, tlast, tuser, e[73:10], e[9:2], e[1], e[0]);
                    end
                end
                hs_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        exp_q.push_back({d, k, l, u});
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input logic u);
        mac_tdata  = d;
        mac_tlast  = l;
        mac_tuser  = u;
        mac_tvalid = 1'b1;
        @(posedge clk);
        #1;
        mac_tvalid = 1'b0;
        mac_tlast  = 1'b0;
        mac_tuser  = 1'b0;
    endtask

    // Contiguous frame base, base+1, ...; tready drops before byte stall_from.
    task automatic send_frame(input logic [7:0] base, input int len, input logic user, input int stall_from);
        for (int i = 0; i < len; i++) begin
            if (i == stall_from) tready = 1'b0;
            send_byte(base + 8'(i), (i == len - 1), (i == len - 1) && user);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n = n + 1;
        end
        #1;
        chk(name, 74'(exp_q.size()), 74'd0);
    endtask

    initial begin
        int ovf_base;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {tdata, tkeep, tvalid, tlast, tuser, overflow}, 74'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 16-byte frame with first-beat latency check
        push(64'h0706050403020100, 8'hFF, 1'b0, 1'b0);
        push(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), (i == 15), 1'b0);
            if (i == 6) chk("tvalid_after_byte6", 74'(tvalid), 74'd0);
            if (i == 7) chk("tvalid_after_byte7", 74'(tvalid), 74'd1);
        end
        wait_drain("drain_16byte");

        // 11-byte frame, bad-frame flag on last byte
        push(64'hA7A6A5A4A3A2A1A0, 8'hFF, 1'b0, 1'b0);
        push(64'h0000000000AAA9A8, 8'h07, 1'b1, 1'b1);
        send_frame(8'hA0, 11, 1'b1, -1);
        wait_drain("drain_11byte");

        // Four back-to-back 1-byte frames
        ovf_base = ovf_cnt;
        hs_cyc_q.delete();
        push(64'h0000000000000011, 8'h01, 1'b1, 1'b0);
        push(64'h0000000000000022, 8'h01, 1'b1, 1'b0);
        push(64'h0000000000000033, 8'h01, 1'b1, 1'b0);
        push(64'h0000000000000044, 8'h01, 1'b1, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(8'h44, 1'b1, 1'b0);
        wait_drain("drain_b2b");
        chk("b2b_beats", 74'(hs_cyc_q.size()), 74'd4);
        if (hs_cyc_q.size() == 4) chk("b2b_span", 74'(hs_cyc_q[3] - hs_cyc_q[0]), 74'd3);
        chk("b2b_no_overflow", 74'(ovf_cnt - ovf_base), 74'd0);

        // 24-byte frame, stall from byte 8: overflow at byte 15, abort beat
        ovf_base = ovf_cnt;
        push(64'h4746454443424140, 8'hFF, 1'b0, 1'b0);
        push(64'h0000000000000000, 8'h01, 1'b1, 1'b1);
        push(64'h6766656463626160, 8'hFF, 1'b1, 1'b0);
        send_frame(8'h40, 24, 1'b0, 8);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf24_pulses", 74'(ovf_cnt - ovf_base), 74'd1);
        chk("ovf24_held_beat", {tdata, tkeep, tvalid}, {64'h4746454443424140, 8'hFF, 1'b1});
        tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send_frame(8'h60, 8, 1'b0, -1);
        wait_drain("drain_ovf24");

        // Stall persisting across a gap into the next frame
        ovf_base = ovf_cnt;
        push(64'h8786858483828180, 8'hFF, 1'b0, 1'b0);
        push(64'h0000000000000000, 8'h01, 1'b1, 1'b1);
        push(64'h0000000000B2B1B0, 8'h07, 1'b1, 1'b0);
        send_frame(8'h80, 16, 1'b0, 8);
        repeat (3) @(posedge clk);
        #1;
        send_frame(8'h90, 5, 1'b0, -1);
        repeat (2) @(posedge clk);
        #1;
        tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send_frame(8'hB0, 3, 1'b0, -1);
        wait_drain("drain_gap");
        chk("gap_pulses", 74'(ovf_cnt - ovf_base), 74'd1);

        // Reset mid-frame while output holds a beat
        tready = 1'b0;
        send_frame(8'hC0, 8, 1'b0, -1);
        for (int i = 0; i < 5; i++) send_byte(8'hD0 + 8'(i), 1'b0, 1'b0);
        chk("held_before_reset", 74'(tvalid), 74'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_async_outputs", {tdata, tkeep, tvalid, tlast, tuser, overflow}, 74'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tready = 1'b1;
        @(posedge clk);
        #1;
        push(64'h0000000000030201, 8'h07, 1'b1, 1'b0);
        send_frame(8'h01, 3, 1'b0, -1);
        wait_drain("drain_after_reset");

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
